// File: rtl/nn_lstm_bptt_sched.sv
// ---------------------------------------------------------------------------
// nn_lstm_bptt_sched
//
// Sequencer for the LSTM back-propagation-through-time delta datapath. It
// walks the stored time steps from T_STEPS-1 down to 0. For each step it
// issues a one-cycle clear to the datapath, opens a STREAM_LEN-cycle
// bitstream window, drives the 2-bit R_condition pattern from an LFSR, and
// flags the first processed step so the delta_*_next inputs can be gated.
//
// Optional feature (compile-time macro NN_BPTT_TRUNC_EN):
//   adds input trunc_len, latched on start. The pass runs
//   min(trunc_len, T_STEPS) steps, with 0 meaning T_STEPS. The walk still
//   starts at T_STEPS-1.
//
// Ports:
//   CLK        in   clock, rising edge
//   INIT       in   asynchronous active-high reset
//   start      in   begin a pass (sampled only in IDLE)
//   abort      in   synchronous cancel back to IDLE, no done
//   stall      in   freeze the stream window (RUN only)
//   trunc_len  in   [TW:0] step limit (NN_BPTT_TRUNC_EN only)
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at the end of a pass
//   t_idx      out  [TW-1:0] current time index / history address
//   step_clr   out  one-cycle datapath clear per step
//   stream_en  out  bitstream-valid strobe
//   first_step out  high throughout the step with t_idx == T_STEPS-1
//   step_done  out  one-cycle pulse at the end of each step
//   rc         out  [1:0] R_condition bits, zero outside RUN
// ---------------------------------------------------------------------------
module nn_lstm_bptt_sched #(
  parameter int          T_STEPS    = 8,
  parameter int          STREAM_LEN = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          TW         = (T_STEPS > 1) ? $clog2(T_STEPS) : 1,
  parameter int          CW         = $clog2(STREAM_LEN + 1)
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
`ifdef NN_BPTT_TRUNC_EN
  input  logic [TW:0]   trunc_len,
`endif
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] t_idx,
  output logic          step_clr,
  output logic          stream_en,
  output logic          first_step,
  output logic          step_done,
  output logic [1:0]    rc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STEP_END,
    S_DONE
  } state_t;

  localparam logic [TW-1:0] T_LAST   = TW'(T_STEPS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STREAM_LEN - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] t_idx_q, t_idx_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [15:0]   lfsr_q,  lfsr_d;
  logic [1:0]    rc_q,    rc_d;
  logic [15:0]   lfsr_step;
  logic          last_step;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

`ifdef NN_BPTT_TRUNC_EN
  // Steps remaining after the current one; the pass ends when it hits zero.
  logic [TW-1:0] rem_q, rem_d;
  logic [TW:0]   trunc_steps;

  always_comb begin
    if (trunc_len == '0 || trunc_len > (TW+1)'(T_STEPS)) trunc_steps = (TW+1)'(T_STEPS);
    else                                                   trunc_steps = trunc_len;
  end

  assign last_step = (rem_q == '0);
`else
  assign last_step = (t_idx_q == '0);
`endif

  always_comb begin
    // NOTE: every combinational output and next-state value gets a default
    // here, so no path through the case below can infer a latch.
    state_d   = state_q;
    t_idx_d   = t_idx_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    done      = 1'b0;
    step_clr  = 1'b0;
    stream_en = 1'b0;
    step_done = 1'b0;
`ifdef NN_BPTT_TRUNC_EN
    rem_d     = rem_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          t_idx_d = T_LAST;
          lfsr_d  = LFSR_SEED;
          cnt_d   = '0;
`ifdef NN_BPTT_TRUNC_EN
          rem_d   = TW'(trunc_steps - (TW+1)'(1));
`endif
        end
      end
      S_CLEAR: begin
        step_clr = 1'b1;
        cnt_d    = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // A stalled cycle is not consumed: counter and LFSR both hold.
        if (!stall) begin
          stream_en = 1'b1;
          cnt_d     = cnt_q + CW'(1);
          lfsr_d    = lfsr_step;
          if (cnt_q == CNT_LAST) state_d = S_STEP_END;
        end
      end
      S_STEP_END: begin
        step_done = 1'b1;
        if (last_step) begin
          state_d = S_DONE;
        end else begin
          t_idx_d = t_idx_q - TW'(1);
`ifdef NN_BPTT_TRUNC_EN
          rem_d   = rem_q - TW'(1);
`endif
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything except in IDLE, where start keeps priority.
    // The pulses of the aborted cycle are suppressed and t_idx holds.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      t_idx_d   = t_idx_q;
      done      = 1'b0;
      step_clr  = 1'b0;
      step_done = 1'b0;
    end

    // rc mirrors the LFSR state the next cycle will see, and is zero
    // whenever that cycle is not a RUN cycle.
    rc_d = (state_d == S_RUN) ? {lfsr_d[8], lfsr_d[0]} : 2'b00;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state_q <= S_IDLE;
      t_idx_q <= '0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      rc_q    <= 2'b00;
`ifdef NN_BPTT_TRUNC_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      t_idx_q <= t_idx_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rc_q    <= rc_d;
`ifdef NN_BPTT_TRUNC_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign t_idx      = t_idx_q;
  assign rc         = rc_q;
  assign first_step = busy && (t_idx_q == T_LAST) && (state_q != S_DONE);

endmodule

// File: doc/nn_lstm_bptt_sched.md
Name: nn_lstm_bptt_sched

Overview:
- Sequencer for the LSTM back-propagation-through-time delta datapath.
- Walks the stored time steps in reverse order, from T_STEPS-1 down to 0.
- For each step it:
  - issues a local clear to the datapath's SS_ADDSUB counters;
  - opens a stochastic-stream window of STREAM_LEN cycles;
  - drives the 2-bit rc R_condition pattern from an LFSR;
  - flags the first step, so the delta_*_next inputs are gated to zero.
- Sits between the training FSM (start/done) and one NN_LSTM_DELTABPTT_POLAR layer plus its history memory (indexed by t_idx).

Parameters:
- T_STEPS, 8, number of unrolled time steps; must be >=1.
- STREAM_LEN, 256, bitstream cycles per time step; must be >=2.
- LFSR_SEED, 16'hACE1, LFSR load value; must be nonzero.
- TW, $clog2(T_STEPS) (minimum 1), width of the time index.
- CW, $clog2(STREAM_LEN+1), width of the stream counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- INIT  in  1  reset, asynchronous, active-high.
- start  in  1  begin a BPTT pass; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE with no done.
- stall  in  1  freeze the stream window; honoured only in RUN.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- t_idx  out  TW  current time index (history address).
- step_clr  out  1  one-cycle datapath clear pulse per step.
- stream_en  out  1  datapath bitstream-valid strobe.
- first_step  out  1  high for the whole step while t_idx==T_STEPS-1 (first processed step).
- step_done  out  1  one-cycle pulse at the end of each step.
- rc  out  2  R_condition bits for the datapath ADDSUB units.

Behaviour:
- Reset (INIT=1, asynchronous) forces:
  - state=IDLE; all outputs 0, including t_idx=0 and rc=0;
  - LFSR=LFSR_SEED; stream counter=0.
- State machine:
  - IDLE: start=1 → CLEAR; t_idx loads T_STEPS-1; LFSR reloads LFSR_SEED; counter=0.
  - CLEAR (1 cycle): step_clr=1, stream_en=0 → RUN.
  - RUN:
    - Per cycle with stall=0: stream_en=1; counter increments; LFSR advances.
    - When the counter reaches STREAM_LEN-1 on an unstalled cycle → STEP_END.
    - With stall=1: stream_en=0; counter, LFSR and rc hold.
  - STEP_END (1 cycle): step_done=1.
    - If t_idx==0 → DONE.
    - Otherwise t_idx decrements and the next state is CLEAR.
  - DONE (1 cycle): done=1 → IDLE; t_idx holds its final value.
- LFSR and rc:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  - rc[0]=lfsr[0], rc[1]=lfsr[8]; rc is registered from the LFSR.
  - rc is valid whenever stream_en=1 and forced to 0 outside RUN.
- first_step: combinational, equal to (busy && t_idx==T_STEPS-1 && state != DONE).
- Latency:
  - start sampled at edge k: step_clr at k+1; first stream_en at k+2.
  - Each step takes STREAM_LEN+2 cycles without stall.
  - done at edge k+1+T_STEPS*(STREAM_LEN+2), plus one cycle per stalled RUN cycle.
- Boundary conditions:
  - start while busy: ignored.
  - abort in any non-IDLE state: IDLE next cycle; done, step_done and step_clr not asserted; t_idx holds.
  - abort and start together in IDLE: start wins, because abort has no effect in IDLE.
  - stall outside RUN: no effect.
  - stall held on the final RUN cycle: that cycle is not consumed.
  - T_STEPS=1: a single step; first_step high throughout the step; STEP_END → DONE.
  - INIT mid-pass: immediate return to IDLE, with all outputs at their reset values.

Optional Feature:
- Macro: NN_BPTT_TRUNC_EN.
- Defined:
  - Adds input port trunc_len (width TW+1), latched on start.
  - Number of steps = min(trunc_len, T_STEPS); trunc_len=0 means T_STEPS.
  - Walk still starts at T_STEPS-1; STEP_END goes to DONE when the step count is reached, instead of at t_idx==0.
- Undefined: port absent; all T_STEPS steps run.

Test Plan:
- T_STEPS=4, STREAM_LEN=8, start pulse at cycle 0, no stall:
  - step_clr at cycles 1, 11, 21, 31;
  - t_idx sequence 3, 2, 1, 0;
  - stream_en high 8 cycles per step;
  - done at cycle 41; busy low at cycle 42.
- Same configuration, stall held 3 cycles mid-RUN of step t=2:
  - stream_en low for those 3 cycles; rc frozen;
  - done at cycle 44; the second step's window length is still 8.
- Reset then start:
  - rc sequence in the first RUN matches a golden model from seed 16'hACE1;
  - a second pass reproduces the identical sequence.
- abort during RUN of t=1: busy low next cycle; done never pulses; a new start succeeds from t_idx=3.
- first_step high exactly during the step with t_idx=3, including its CLEAR and STEP_END cycles; low otherwise.
- With NN_BPTT_TRUNC_EN, trunc_len=2: t_idx sequence 3, 2; done at cycle 21.
